// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit data memory and load path.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  function automatic int unsigned size_bytes(input lsu_size_e size);
    return 32'd1 << size;
  endfunction

  // Operates on a 64-bit container; narrower datapaths use the low bits.
  function automatic logic [63:0] extend(input logic [63:0] data, input lsu_size_e size,
                                         input logic is_unsigned);
    logic [63:0] res;
    unique case (size)
      SZ_B:    res = is_unsigned ? {56'b0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
      SZ_H:    res = is_unsigned ? {48'b0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      SZ_W:    res = is_unsigned ? {32'b0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational sign/zero extender for sized loads.
module lsu_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] data,
  input  lsu_size_e       size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [63:0] wide;

  assign wide   = extend(64'(data), size, is_unsigned);
  assign result = wide[XLEN-1:0];

endmodule

// File: rtl/lsu_data_memory.sv
// Byte-addressable little-endian data memory with req/ready handshake,
// configurable wait states, sized accesses and a post-reset clear sequence.
module lsu_data_memory
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [XLEN-1:0]                req_addr,
  input  logic [1:0]                     req_size,
  input  logic                           req_unsigned,
  input  logic [XLEN-1:0]                req_wdata,
  output logic                           rsp_valid,
  output logic [XLEN-1:0]                rsp_rdata,
  output logic                           rsp_error,
  output logic                           init_done,
  input  logic [$clog2(DEPTH_BYTES)-1:0] probe_addr,
  output logic [XLEN-1:0]                probe_data
);

  localparam int AW     = $clog2(DEPTH_BYTES);
  localparam int WB     = XLEN / 8;
  localparam int OFF    = $clog2(WB);
  localparam int NWORDS = DEPTH_BYTES / WB;
  localparam int CW     = (AW - OFF > 0) ? AW - OFF : 1;

  logic [7:0]      mem [DEPTH_BYTES];
  lsu_state_e      state, state_nxt;
  logic [CW-1:0]   clr_cnt;
  logic [3:0]      wait_cnt;
  logic [XLEN-1:0] l_addr, l_wdata;
  lsu_size_e       l_size;
  logic            l_write, l_unsigned;
  logic            clr_last, wait_last;
  logic            misalign, out_of_range, illegal_size, err;
  int unsigned     sb;
  logic [AW-1:0]   l_idx, clr_base, probe_base;
  logic [XLEN-1:0] rd_raw, rd_ext;

  assign clr_last  = (clr_cnt == CW'(NWORDS - 1));
  assign wait_last = (wait_cnt == 4'(WAIT_STATES - 1));

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    unique case (state)
      ST_INIT: if (clr_last) state_nxt = ST_IDLE;
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: if (wait_last) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt    <= '0;
      wait_cnt   <= '0;
      init_done  <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_size     <= SZ_B;
      l_write    <= 1'b0;
      l_unsigned <= 1'b0;
    end else begin
      clr_cnt  <= (state == ST_INIT) ? clr_cnt + 1'b1 : '0;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == ST_INIT && clr_last) init_done <= 1'b1;
      if (state == ST_IDLE && req_valid) begin
        l_addr     <= req_addr;
        l_wdata    <= req_wdata;
        l_size     <= lsu_size_e'(req_size);
        l_write    <= req_write;
        l_unsigned <= req_unsigned;
      end
    end
  end

  // Error checks use a carry bit so addresses near the top of XLEN cannot wrap into range.
  always_comb begin
    sb           = size_bytes(l_size);
    misalign     = (l_addr & XLEN'(sb - 1)) != '0;
    out_of_range = ({1'b0, l_addr} + (XLEN+1)'(sb)) > (XLEN+1)'(DEPTH_BYTES);
    illegal_size = (XLEN == 32) && (l_size == SZ_D);
    err          = misalign || out_of_range || illegal_size;
  end

  assign l_idx      = l_addr[AW-1:0];
  assign clr_base   = AW'(clr_cnt) << OFF;
  assign probe_base = probe_addr & ~AW'(WB - 1);

  always_comb begin
    rd_raw     = '0;
    probe_data = '0;
    for (int unsigned i = 0; i < WB; i++) begin
      rd_raw[8*i +: 8]     = mem[l_idx + AW'(i)];
      probe_data[8*i +: 8] = mem[probe_base + AW'(i)];
    end
  end

  lsu_extend #(.XLEN(XLEN)) u_extend (
    .data       (rd_raw),
    .size       (l_size),
    .is_unsigned(l_unsigned),
    .result     (rd_ext)
  );

  assign rsp_valid = (state == ST_RESP);
  assign rsp_error = rsp_valid && err;
  assign rsp_rdata = (rsp_valid && !err && !l_write) ? rd_ext : '0;

  // Storage has no reset; an asserted reset suppresses the pending edge's write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        for (int unsigned i = 0; i < WB; i++) mem[clr_base + AW'(i)] <= '0;
      end else if (state == ST_RESP && l_write && !err) begin
        for (int unsigned i = 0; i < WB; i++)
          if (i < sb) mem[l_idx + AW'(i)] <= l_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed bench: dut_a has no wait states, dut_b has three.
module tb_lsu_data_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          total = 0;
  int          bad = 0;

  logic        a_valid = 0, a_write = 0, a_uns = 0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [1:0]  a_size = '0;
  logic [7:0]  a_probe_addr = '0;
  logic        a_ready, a_rsp_valid, a_err, a_init_done;
  logic [63:0] a_rdata, a_probe_data;

  logic        b_valid = 0, b_write = 0, b_uns = 0;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic [1:0]  b_size = '0;
  logic [7:0]  b_probe_addr = '0;
  logic        b_ready, b_rsp_valid, b_err, b_init_done;
  logic [63:0] b_rdata, b_probe_data;

  always #5 clk = ~clk;

  lsu_data_memory #(.XLEN(64), .DEPTH_BYTES(256), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_addr(a_addr), .req_size(a_size), .req_unsigned(a_uns),
    .req_wdata(a_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_error(a_err),
    .init_done(a_init_done), .probe_addr(a_probe_addr), .probe_data(a_probe_data)
  );

  lsu_data_memory #(.XLEN(64), .DEPTH_BYTES(256), .WAIT_STATES(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_addr(b_addr), .req_size(b_size), .req_unsigned(b_uns),
    .req_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_error(b_err),
    .init_done(b_init_done), .probe_addr(b_probe_addr), .probe_data(b_probe_data)
  );

  // One transaction on dut_a; lat is the number of cycles from acceptance to rsp_valid, -1 on timeout.
  task automatic txn_a(input logic w, input logic [63:0] addr, input logic [1:0] sz,
                       input logic uns, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int lat);
    rd = '0; er = 1'b0; lat = -1;
    @(negedge clk);
    a_valid = 1'b1; a_write = w; a_addr = addr; a_size = sz; a_uns = uns; a_wdata = wd;
    for (int i = 0; i < 20 && !a_ready; i++) @(negedge clk);
    if (a_ready) begin
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        if (a_rsp_valid) begin
          lat = k; rd = a_rdata; er = a_err;
          break;
        end
        @(negedge clk);
      end
    end else begin
      a_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(negedge clk);
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", a_ready); end
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", a_rsp_valid); end
    total++; if (a_rdata !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", a_rdata); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", a_err); end
    total++; if (a_init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b want=0", a_init_done); end
    reset = 1'b0;
    n = 0;
    while (a_init_done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++; if (n !== 32) begin bad++; $display("FAIL init_cycles got=%0d want=32", n); end
    total++; if (b_init_done !== 1'b1) begin bad++; $display("FAIL init_done_b got=%b want=1", b_init_done); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", a_ready); end
    a_probe_addr = 8'd0; #1;
    total++; if (a_probe_data !== 64'h0) begin bad++; $display("FAIL probe0 got=%h want=0", a_probe_data); end
    a_probe_addr = 8'd8; #1;
    total++; if (a_probe_data !== 64'h0) begin bad++; $display("FAIL probe8 got=%h want=0", a_probe_data); end
    a_probe_addr = 8'd248; #1;
    total++; if (a_probe_data !== 64'h0) begin bad++; $display("FAIL probe248 got=%h want=0", a_probe_data); end
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic er; int lat;
    txn_a(1'b1, 64'h10, 2'b11, 1'b0, 64'h8877665544332211, rd, er, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL st_d_latency got=%0d want=1", lat); end
    total++; if (er !== 1'b0 || rd !== 64'h0) begin bad++; $display("FAIL st_d_rsp got=%b/%h want=0/0", er, rd); end
    txn_a(1'b0, 64'h17, 2'b00, 1'b0, 64'h0, rd, er, lat);
    total++; if (lat !== 1 || rd !== 64'hFFFFFFFFFFFFFF88) begin bad++; $display("FAIL ld_b_signed got=%h lat=%0d want=ffffffffffffff88 lat=1", rd, lat); end
    txn_a(1'b0, 64'h17, 2'b00, 1'b1, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h88) begin bad++; $display("FAIL ld_b_unsigned got=%h want=88", rd); end
    txn_a(1'b0, 64'h16, 2'b01, 1'b0, 64'h0, rd, er, lat);
    total++; if (rd !== 64'hFFFFFFFFFFFF8877) begin bad++; $display("FAIL ld_h_signed got=%h want=ffffffffffff8877", rd); end
    txn_a(1'b0, 64'h14, 2'b10, 1'b0, 64'h0, rd, er, lat);
    total++; if (rd !== 64'hFFFFFFFF88776655) begin bad++; $display("FAIL ld_w_signed got=%h want=ffffffff88776655", rd); end
    txn_a(1'b0, 64'h10, 2'b11, 1'b1, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h8877665544332211 || er !== 1'b0) begin bad++; $display("FAIL ld_d got=%h/%b want=8877665544332211/0", rd, er); end
  endtask

  task automatic test_store_half();
    logic [63:0] rd; logic er; int lat;
    txn_a(1'b1, 64'h22, 2'b01, 1'b0, 64'h123456789ABCBEEF, rd, er, lat);
    txn_a(1'b0, 64'h20, 2'b10, 1'b1, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h00000000BEEF0000) begin bad++; $display("FAIL ld_w_unsigned got=%h want=00000000beef0000", rd); end
    a_probe_addr = 8'h20; #1;
    total++; if (a_probe_data !== 64'h00000000BEEF0000) begin bad++; $display("FAIL probe20 got=%h want=00000000beef0000", a_probe_data); end
    a_probe_addr = 8'h25; #1;
    total++; if (a_probe_data !== 64'h00000000BEEF0000) begin bad++; $display("FAIL probe25 got=%h want=00000000beef0000", a_probe_data); end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int lat;
    txn_a(1'b0, 64'h13, 2'b10, 1'b0, 64'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 64'h0) begin bad++; $display("FAIL misalign_w got=%b/%h want=1/0", er, rd); end
    txn_a(1'b1, 64'hF8, 2'b11, 1'b0, 64'h1122334455667788, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL st_d_top got=%b want=0", er); end
    txn_a(1'b1, 64'hFC, 2'b11, 1'b0, 64'hAAAAAAAAAAAAAAAA, rd, er, lat);
    total++; if (er !== 1'b1 || lat !== 1) begin bad++; $display("FAIL st_d_fc_err got=%b lat=%0d want=1 lat=1", er, lat); end
    a_probe_addr = 8'hF8; #1;
    total++; if (a_probe_data !== 64'h1122334455667788) begin bad++; $display("FAIL probe_f8 got=%h want=1122334455667788", a_probe_data); end
    txn_a(1'b0, 64'hFF, 2'b00, 1'b1, 64'h0, rd, er, lat);
    total++; if (er !== 1'b0 || rd !== 64'h11) begin bad++; $display("FAIL ld_b_last got=%b/%h want=0/11", er, rd); end
    txn_a(1'b0, 64'hFF, 2'b01, 1'b1, 64'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 64'h0) begin bad++; $display("FAIL ld_h_ff got=%b/%h want=1/0", er, rd); end
    txn_a(1'b0, 64'h100, 2'b10, 1'b0, 64'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 64'h0) begin bad++; $display("FAIL ld_w_oor got=%b/%h want=1/0", er, rd); end
    txn_a(1'b1, 64'h100, 2'b00, 1'b0, 64'hAA, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL st_b_oor got=%b want=1", er); end
    a_probe_addr = 8'h00; #1;
    total++; if (a_probe_data !== 64'h0) begin bad++; $display("FAIL probe0_after_oor got=%h want=0", a_probe_data); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b0; a_addr = 64'h10; a_size = 2'b00; a_uns = 1'b1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b want=1", a_ready); end
    @(negedge clk);
    total++; if (a_rsp_valid !== 1'b1 || a_rdata !== 64'h11 || a_ready !== 1'b0) begin bad++; $display("FAIL b2b_rsp1 got=%b/%h/%b want=1/11/0", a_rsp_valid, a_rdata, a_ready); end
    a_addr = 64'h11;
    @(negedge clk);
    total++; if (a_rsp_valid !== 1'b0 || a_rdata !== 64'h0 || a_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap got=%b/%h/%b want=0/0/1", a_rsp_valid, a_rdata, a_ready); end
    @(negedge clk);
    total++; if (a_rsp_valid !== 1'b1 || a_rdata !== 64'h22) begin bad++; $display("FAIL b2b_rsp2 got=%b/%h want=1/22", a_rsp_valid, a_rdata); end
    a_valid = 1'b0;
    @(negedge clk);
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b want=0", a_rsp_valid); end
  endtask

  task automatic test_wait_states();
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b1; b_addr = 64'h8; b_size = 2'b11; b_uns = 1'b0;
    b_wdata = 64'h0123456789ABCDEF;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL ws_ready_idle got=%b want=1", b_ready); end
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if (b_rsp_valid !== (k == 4)) begin bad++; $display("FAIL ws_rsp_valid_n%0d got=%b want=%b", k, b_rsp_valid, (k == 4)); end
      total++; if (b_ready !== (k == 5)) begin bad++; $display("FAIL ws_ready_n%0d got=%b want=%b", k, b_ready, (k == 5)); end
      if (k == 4 && b_err !== 1'b0) begin total++; bad++; $display("FAIL ws_err got=%b want=0", b_err); end
      if (k == 5) b_valid = 1'b0;
    end
    @(negedge clk);
    total++; if (b_rsp_valid !== 1'b0 || b_ready !== 1'b1) begin bad++; $display("FAIL ws_no_extra got=%b/%b want=0/1", b_rsp_valid, b_ready); end
    b_probe_addr = 8'h08; #1;
    total++; if (b_probe_data !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL ws_probe8 got=%h want=0123456789abcdef", b_probe_data); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int n = 0;
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b1; b_addr = 64'h30; b_size = 2'b11; b_wdata = 64'hDEADBEEFCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (b_rsp_valid) seen = 1;
    end
    total++; if (b_ready !== 1'b0 || b_init_done !== 1'b0) begin bad++; $display("FAIL mid_rst_outputs got=%b/%b want=0/0", b_ready, b_init_done); end
    reset = 1'b0;
    while (b_init_done !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
      if (b_rsp_valid) seen = 1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_rsp got=%b want=0", seen); end
    total++; if (b_init_done !== 1'b1) begin bad++; $display("FAIL mid_rst_init got=%b want=1", b_init_done); end
    b_probe_addr = 8'h30; #1;
    total++; if (b_probe_data !== 64'h0) begin bad++; $display("FAIL mid_rst_probe30 got=%h want=0", b_probe_data); end
    b_probe_addr = 8'h08; #1;
    total++; if (b_probe_data !== 64'h0) begin bad++; $display("FAIL mid_rst_probe8 got=%h want=0", b_probe_data); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_store_half();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
